// File: rtl/matrix_scan_pkg.sv
// Shared types and default sizing for the LED matrix scan driver.
// Contents:
//   scan_mode_t                  - SCAN_ROW / SCAN_COL line orientation
//   Default{Rows,Cols,Dwell,Blank} - default parameter values
//   max_u()                      - larger of two unsigned ints, for counter sizing
package matrix_scan_pkg;

  typedef enum logic {
    SCAN_ROW = 1'b0,
    SCAN_COL = 1'b1
  } scan_mode_t;

  localparam int unsigned DefaultRows  = 16;
  localparam int unsigned DefaultCols  = 16;
  localparam int unsigned DefaultDwell = 1024;
  localparam int unsigned DefaultBlank = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Scan timing for the matrix driver: dwell counter within a line and line counter within a frame.
// Ports:
//   clock_i     - clock, rising edge
//   reset_i     - synchronous active-high reset
//   line_last_i - index of the last line of the current frame (L-1)
//   dwell_o     - dwell count 0..DWELL-1
//   line_o      - line count 0..line_last_i
//   eof_o       - high on the last dwell cycle of the last line
module matrix_scan_timer #(
  parameter int unsigned DWELL  = 1024,
  parameter int unsigned DwellW = 10,
  parameter int unsigned LineW  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [LineW-1:0]  line_last_i,
  output logic [DwellW-1:0] dwell_o,
  output logic [LineW-1:0]  line_o,
  output logic              eof_o
);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL - 1);

  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [LineW-1:0]  line_q, line_d;
  logic              eol;

  assign eol   = (dwell_q == DwellLast);
  assign eof_o = eol && (line_q == line_last_i);

  always_comb begin
    dwell_d = dwell_q + DwellW'(1);
    line_d  = line_q;
    if (eol) begin
      dwell_d = '0;
      line_d  = (line_q == line_last_i) ? '0 : line_q + LineW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      dwell_q <= '0;
      line_q  <= '0;
    end else begin
      dwell_q <= dwell_d;
      line_q  <= line_d;
    end
  end

  assign dwell_o = dwell_q;
  assign line_o  = line_q;

endmodule

// File: rtl/matrix_scan_driver.sv
// Double-buffered LED matrix scan driver. A frame offered on frame_data is captured into a
// shadow buffer and promoted to the displayed (active) buffer only at a frame boundary, so a
// displayed frame is never torn. Each line is blanked for BLANK cycles before being driven.
// Optional feature: define MATRIX_SCAN_COLSCAN_EN to alternate row-scan and column-scan frames.
// Ports:
//   clock       - clock, rising edge
//   reset       - synchronous active-high reset
//   frame_data  - pixel (r,c) at bit r*COLS+c, 1 = lit
//   frame_valid - frame_data offered
//   frame_ready - shadow buffer empty, a frame can be accepted
//   row         - active-high row drive (registered)
//   col         - active-low column drive (registered)
//   frame_done  - one-cycle pulse on the last cycle of each displayed frame
module matrix_scan_driver
  import matrix_scan_pkg::*;
#(
  parameter int unsigned ROWS  = DefaultRows,
  parameter int unsigned COLS  = DefaultCols,
  parameter int unsigned DWELL = DefaultDwell,
  parameter int unsigned BLANK = DefaultBlank
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [0:ROWS*COLS-1] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [0:ROWS-1]      row,
  output logic [0:COLS-1]      col,
  output logic                 frame_done
);

  localparam int unsigned DwellW = $clog2(DWELL);
  localparam int unsigned LineW  = $clog2(max_u(ROWS, COLS));
  localparam logic [DwellW-1:0] BlankEnd = DwellW'(BLANK);

  logic [DwellW-1:0] dwell;
  logic [LineW-1:0]  line;
  logic [LineW-1:0]  line_last;
  logic              eof;

  logic [0:ROWS*COLS-1] active_q, active_d;
  logic [0:ROWS*COLS-1] shadow_q, shadow_d;
  logic                 full_q, full_d;
  logic [0:ROWS-1]      row_q, row_d;
  logic [0:COLS-1]      col_q, col_d;
  logic                 accept;

  matrix_scan_timer #(
    .DWELL  (DWELL),
    .DwellW (DwellW),
    .LineW  (LineW)
  ) u_timer (
    .clock_i     (clock),
    .reset_i     (reset),
    .line_last_i (line_last),
    .dwell_o     (dwell),
    .line_o      (line),
    .eof_o       (eof)
  );

`ifdef MATRIX_SCAN_COLSCAN_EN
  scan_mode_t mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (eof) begin
      mode_d = (mode_q == SCAN_ROW) ? SCAN_COL : SCAN_ROW;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q <= SCAN_ROW;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign line_last = (mode_q == SCAN_COL) ? LineW'(COLS - 1) : LineW'(ROWS - 1);
`else
  assign line_last = LineW'(ROWS - 1);
`endif

  // Accept and swap are exclusive: accept needs an empty shadow, swap a full one.
  assign accept = frame_valid && !full_q;

  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    if (accept) begin
      shadow_d = frame_data;
      full_d   = 1'b1;
    end else if (eof && full_q) begin
      active_d = shadow_q;
      full_d   = 1'b0;
    end
  end

  // Pin values are computed from the current counter state and registered below.
  always_comb begin
    row_d = '0;
    col_d = '1;
    if (dwell >= BlankEnd) begin
`ifdef MATRIX_SCAN_COLSCAN_EN
      if (mode_q == SCAN_COL) begin
        for (int c = 0; c < COLS; c++) begin
          if (line == LineW'(c)) begin
            col_d[c] = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
              row_d[r] = active_q[r*COLS+c];
            end
          end
        end
      end else begin
`endif
        for (int r = 0; r < ROWS; r++) begin
          if (line == LineW'(r)) begin
            row_d[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
              col_d[c] = ~active_q[r*COLS+c];
            end
          end
        end
`ifdef MATRIX_SCAN_COLSCAN_EN
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '1;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign frame_ready = ~full_q;
  assign row         = row_q;
  assign col         = col_q;
  assign frame_done  = eof && !reset;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver (ROWS=4, COLS=4, DWELL=8, BLANK=2): a table of
// checkpoint vectors, hand sequences for overwrite, swap-timing and reset corners, and random
// traffic checked against a frame-position reference model.
module tb_matrix_scan_driver;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int N     = ROWS * COLS;
  localparam int NCAP  = 70;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           frame_valid = 1'b0;
  logic [0:N-1]   frame_data = '0;
  logic           frame_ready;
  logic [0:ROWS-1] row;
  logic [0:COLS-1] col;
  logic           frame_done;

  int checks = 0;
  int errors = 0;

  matrix_scan_driver #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .row         (row),
    .col         (col),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: position within the frame, buffers, and the expected pin values.
  bit              m_known = 0;
  int              m_pos;
  bit              m_colscan;
  logic [0:N-1]    m_active, m_shadow;
  bit              m_full;
  logic [0:ROWS-1] m_row;
  logic [0:COLS-1] m_col;

  // Outputs sampled by the last tick.
  logic [0:ROWS-1] s_row;
  logic [0:COLS-1] s_col;
  logic            s_rdy, s_done;

  function automatic int lines();
    return m_colscan ? COLS : ROWS;
  endfunction

  function automatic void model_step(input logic v, input logic [0:N-1] d, input logic rst);
    int line, dw;
    bit last;
    if (rst) begin
      m_pos = 0; m_colscan = 0; m_active = '0; m_full = 0;
      m_row = '0; m_col = '1; m_known = 1;
      return;
    end
    line = m_pos / DWELL;
    dw   = m_pos % DWELL;
    m_row = '0;
    m_col = '1;
    if (dw >= BLANK) begin
      if (!m_colscan) begin
        m_row[line] = 1'b1;
        for (int c = 0; c < COLS; c++) m_col[c] = !m_active[line*COLS+c];
      end else begin
        m_col[line] = 1'b0;
        for (int r = 0; r < ROWS; r++) m_row[r] = m_active[r*COLS+line];
      end
    end
    last = (m_pos == lines() * DWELL - 1);
    if (v && !m_full) begin
      m_shadow = d;
      m_full   = 1;
    end else if (last && m_full) begin
      m_active = m_shadow;
      m_full   = 0;
    end
    if (last) begin
      m_pos = 0;
`ifdef MATRIX_SCAN_COLSCAN_EN
      m_colscan = !m_colscan;
`endif
    end else begin
      m_pos++;
    end
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the falling edge, compare against the model, then step.
  task automatic tick(input logic v, input logic [0:N-1] d, input logic rst);
    bit exp_done;
    frame_valid = v;
    frame_data  = d;
    reset       = rst;
    #1;
    s_row = row; s_col = col; s_rdy = frame_ready; s_done = frame_done;
    if (m_known) begin
      exp_done = !rst && (m_pos == lines() * DWELL - 1);
      check("model_row", 16'(row), 16'(m_row));
      check("model_col", 16'(col), 16'(m_col));
      check("model_frame_ready", 16'(frame_ready), 16'(!m_full));
      check("model_frame_done", 16'(frame_done), 16'(exp_done));
    end
    model_step(v, d, rst);
    @(negedge clock);
  endtask

  typedef struct {
    int              n;
    logic [0:ROWS-1] r;
    logic [0:COLS-1] c;
    logic            rdy;
    logic            dn;
  } vec_t;

  vec_t            tbl [13];
  logic [0:ROWS-1] cap_r [NCAP];
  logic [0:COLS-1] cap_c [NCAP];
  logic            cap_rdy [NCAP];
  logic            cap_dn [NCAP];

  logic [0:N-1] f1, f2;
  bit found, lit_seen;

  initial begin
    f1 = '0; f1[1*COLS+2] = 1'b1;
    f2 = '0; f2[2*COLS+1] = 1'b1;

    // n = cycles after reset release; pins lag the counters by one cycle.
    tbl[0]  = '{0,  4'b0000, 4'b1111, 1'b1, 1'b0};
    tbl[1]  = '{1,  4'b0000, 4'b1111, 1'b0, 1'b0};
    tbl[2]  = '{3,  4'b1000, 4'b1111, 1'b0, 1'b0};
    tbl[3]  = '{11, 4'b0100, 4'b1111, 1'b0, 1'b0};
    tbl[4]  = '{31, 4'b0001, 4'b1111, 1'b0, 1'b1};
    tbl[5]  = '{32, 4'b0001, 4'b1111, 1'b1, 1'b0};
    tbl[6]  = '{33, 4'b0000, 4'b1111, 1'b1, 1'b0};
    tbl[7]  = '{42, 4'b0000, 4'b1111, 1'b1, 1'b0};
    tbl[10] = '{49, 4'b0000, 4'b1111, 1'b1, 1'b0};
`ifdef MATRIX_SCAN_COLSCAN_EN
    tbl[8]  = '{43, 4'b0000, 4'b1011, 1'b1, 1'b0};
    tbl[9]  = '{48, 4'b0000, 4'b1011, 1'b1, 1'b0};
    tbl[11] = '{51, 4'b0100, 4'b1101, 1'b1, 1'b0};
    tbl[12] = '{63, 4'b0000, 4'b1110, 1'b1, 1'b1};
`else
    tbl[8]  = '{43, 4'b0100, 4'b1101, 1'b1, 1'b0};
    tbl[9]  = '{48, 4'b0100, 4'b1101, 1'b1, 1'b0};
    tbl[11] = '{51, 4'b0010, 4'b1111, 1'b1, 1'b0};
    tbl[12] = '{63, 4'b0001, 4'b1111, 1'b1, 1'b1};
`endif

    @(negedge clock);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);

    // Load f1 right after reset; f2 offered while f1 is pending must be ignored.
    for (int n = 0; n < NCAP; n++) begin
      if (n == 0) tick(1'b1, f1, 1'b0);
      else if (n == 10) tick(1'b1, f2, 1'b0);
      else tick(1'b0, '0, 1'b0);
      cap_r[n] = s_row; cap_c[n] = s_col; cap_rdy[n] = s_rdy; cap_dn[n] = s_done;
    end
    for (int i = 0; i < 13; i++) begin
      check($sformatf("vec%0d_n%0d_row", i, tbl[i].n), 16'(cap_r[tbl[i].n]), 16'(tbl[i].r));
      check($sformatf("vec%0d_n%0d_col", i, tbl[i].n), 16'(cap_c[tbl[i].n]), 16'(tbl[i].c));
      check($sformatf("vec%0d_n%0d_ready", i, tbl[i].n), 16'(cap_rdy[tbl[i].n]),
            16'(tbl[i].rdy));
      check($sformatf("vec%0d_n%0d_done", i, tbl[i].n), 16'(cap_dn[tbl[i].n]), 16'(tbl[i].dn));
    end

    // Offer f2 on the frame_done cycle with the shadow empty.
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      #1;
      if (frame_done) found = 1;
      else tick(1'b0, '0, 1'b0);
    end
    check("wait_frame_done_found", 16'(found), 16'd1);
    tick(1'b1, f2, 1'b0);
    check("accept_on_done_pulse", 16'(s_done), 16'd1);
    tick(1'b0, '0, 1'b0);
    check("ready_low_after_accept", 16'(s_rdy), 16'd0);
    for (int k = 0; k < ROWS * DWELL - 2; k++) tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("pending_frame_done", 16'(s_done), 16'd1);
    check("pending_ready_still_low", 16'(s_rdy), 16'd0);
    tick(1'b0, '0, 1'b0);
    check("ready_high_after_swap", 16'(s_rdy), 16'd1);
`ifndef MATRIX_SCAN_COLSCAN_EN
    for (int k = 0; k < 18; k++) tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    check("f2_shown_row", 16'(s_row), 16'(4'b0010));
    check("f2_shown_col", 16'(s_col), 16'(4'b1011));
`endif

    // Reset at line 2, dwell 5 with f1 pending: everything discarded.
    tick(1'b0, '0, 1'b1);
    tick(1'b1, f1, 1'b0);
    for (int k = 1; k < 2 * DWELL + 5; k++) tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    check("post_reset_row", 16'(s_row), 16'(4'b0000));
    check("post_reset_col", 16'(s_col), 16'(4'b1111));
    check("post_reset_ready", 16'(s_rdy), 16'd1);
    lit_seen = 0;
    for (int k = 0; k < 64; k++) begin
      tick(1'b0, '0, 1'b0);
      if (s_col != '1 && s_row != '0) lit_seen = 1;
    end
    check("pending_lost_after_reset", 16'(lit_seen), 16'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 599) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 SHALL have parameter ROWS, default 16: number of matrix rows, minimum 2.
REQ-002 SHALL have parameter COLS, default 16: number of matrix columns, minimum 2.
REQ-003 SHALL have parameter DWELL, default 1024: clock cycles per scan line, minimum 4.
REQ-004 SHALL have parameter BLANK, default 2: blanked cycles at the start of each line; 1 <= BLANK < DWELL.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port frame_data, input, ROWS*COLS bits, ascending [0:N-1]: pixel (r,c) at bit r*COLS+c; 1 = lit.
REQ-008 SHALL have port frame_valid, input, 1 bit: frame_data offered.
REQ-009 SHALL have port frame_ready, output, 1 bit: shadow buffer empty; a frame can be accepted.
REQ-010 SHALL have port row, output, ROWS bits [0:ROWS-1]: active-high row drive.
REQ-011 SHALL have port col, output, COLS bits [0:COLS-1]: active-low column drive.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each displayed frame.

Function
REQ-013 SHALL hold two buffers: active (being displayed) and shadow (pending); frame accepted when frame_valid && frame_ready, captured into shadow, frame_ready low from the next cycle.
REQ-014 SHALL sequence lines with a dwell counter 0..DWELL-1 and a line counter 0..L-1; L = ROWS in row-scan, COLS in column-scan; the line advances when dwell = DWELL-1, wrapping to 0 after L-1.
REQ-015 Row-scan line r, dwell >= BLANK: row one-hot at bit r, col = ~active[r*COLS +: COLS].
REQ-016 While dwell < BLANK: row = all 0, col = all 1 (blanked).
REQ-017 row and col SHALL be registered: one cycle of latency from counter state to pins.
REQ-018 frame_done SHALL pulse on the cycle with line = L-1 and dwell = DWELL-1.
REQ-019 At that same edge, if shadow is full: shadow moves to active, shadow marked empty, frame_ready high on the next cycle; if shadow is empty: active retained and the frame repeats.
REQ-020 frame_valid while frame_ready is low SHALL be ignored; no overwrite of a pending shadow.
REQ-021 Frame swap SHALL occur only at a frame boundary; a displayed frame is never torn.

Reset
REQ-022 On reset: dwell = 0, line = 0, active = all 0, shadow empty, frame_ready = 1, row = all 0, col = all 1, frame_done = 0, mode = row-scan.
REQ-023 Reset mid-frame SHALL discard active and pending data; the first cycle after reset behaves as line 0, dwell 0.

Configuration
REQ-024 With MATRIX_SCAN_COLSCAN_EN defined, scan mode SHALL toggle at every frame end, alternating row-scan and column-scan frames.
REQ-025 Column-scan line c, dwell >= BLANK: col = all 1 except bit c = 0; row[r] = active[r*COLS+c] for all r.
REQ-026 Without MATRIX_SCAN_COLSCAN_EN, mode SHALL be fixed at row-scan; no column-scan logic SHALL be present.

Structure
REQ-027 Package matrix_scan_pkg SHALL hold scan_mode_t (SCAN_ROW, SCAN_COL) and the default parameter constants.
REQ-028 Sub-module matrix_scan_timer SHALL own the dwell and line counters and the end-of-line and end-of-frame strobes; buffers and drive logic stay in matrix_scan_driver.

Verification (ROWS=4, COLS=4, DWELL=8, BLANK=2)
REQ-029 Reset, no load -> row = 0000 and col = 1111 on every cycle; frame_ready = 1; frame_done every 32 cycles.
REQ-030 Load a frame with only pixel (1,2) lit -> in line 1, dwell 2..7: row = 0100, col = 1101; all other lines: col = 1111.
REQ-031 Offer a second frame mid-frame while shadow is full -> ignored, frame_ready = 0; the first pending frame is shown after the next frame_done.
REQ-032 frame_valid asserted on the frame_done cycle with shadow empty -> accepted; displayed from the frame after next; frame_ready = 0 for one frame.
REQ-033 Reset asserted at line 2, dwell 5 -> next cycle counters at 0, outputs blanked, frame_ready = 1, pending frame lost.
REQ-034 With MATRIX_SCAN_COLSCAN_EN, pixel (1,2) lit -> second frame, line 2, dwell >= 2: col = 1101, row = 0100.
